// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer.
package vend_pkg;

  // Default width of credit, coin value and change amount.
  localparam int unsigned DEFAULT_CREDIT_W = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDispense,
    StChange
  } state_e;

  // Timer mode codes driven on start_timer.
  localparam logic [1:0] TMR_WAIT_SELECT    = 2'b00;
  localparam logic [1:0] TMR_PRODUCT_RETURN = 2'b01;
  localparam logic [1:0] TMR_CHANGE_RETURN  = 2'b10;
  localparam logic [1:0] TMR_IDLE           = 2'b11;

endpackage

// File: rtl/price_lookup.sv
// Combinational product price table indexed by the selection id.
module price_lookup #(
  parameter int unsigned          CREDIT_W = 8,
  parameter logic [CREDIT_W-1:0]  PRICE0   = 8'd10,
  parameter logic [CREDIT_W-1:0]  PRICE1   = 8'd15,
  parameter logic [CREDIT_W-1:0]  PRICE2   = 8'd20,
  parameter logic [CREDIT_W-1:0]  PRICE3   = 8'd25
) (
  input  logic [1:0]          sel_id,
  output logic [CREDIT_W-1:0] price
);

  // Map the selection index to its price.
  always_comb begin
    price = '0;
    unique case (sel_id)
      2'd0: price = PRICE0;
      2'd1: price = PRICE1;
      2'd2: price = PRICE2;
      2'd3: price = PRICE3;
      default: price = '0;
    endcase
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending-machine control FSM. Collects coins, prices selections and opens
// the timed wait-select, product-return and change-return phases on the
// external timer via start_timer, closing each phase on timeout_flag.
// Optional feature: define CANCEL_BUTTON_EN to add the cancel input, which
// refunds the full credit from the collect state.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned         CREDIT_W = DEFAULT_CREDIT_W,
  parameter logic [CREDIT_W-1:0] PRICE0   = 8'd10,
  parameter logic [CREDIT_W-1:0] PRICE1   = 8'd15,
  parameter logic [CREDIT_W-1:0] PRICE2   = 8'd20,
  parameter logic [CREDIT_W-1:0] PRICE3   = 8'd25
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef CANCEL_BUTTON_EN
  input  logic                cancel,
`endif
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                timeout_flag,
  output logic [1:0]          start_timer,
  output logic                dispense_valid,
  output logic [1:0]          dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_deny
);

  state_e              state_q;
  logic                restart_q;   // wait-select restart: 11 shown, 00 due next
  logic [1:0]          tmr_prev_q;  // start_timer one cycle ago
  logic                arm_wait_q;  // second cycle of the arming window
  logic                armed;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ovf;
  logic                coin_ok;
  logic [CREDIT_W-1:0] credit_with_coin;
  logic [CREDIT_W:0]   sel_new;
  logic                sel_ok;
  logic                cancel_evt;

  price_lookup #(
    .CREDIT_W (CREDIT_W),
    .PRICE0   (PRICE0),
    .PRICE1   (PRICE1),
    .PRICE2   (PRICE2),
    .PRICE3   (PRICE3)
  ) u_price_lookup (
    .sel_id (sel_id),
    .price  (price)
  );

  // Credit arithmetic, coin acceptance and selection affordability.
  always_comb begin
    coin_sum         = {1'b0, credit} + {1'b0, coin_value};
    coin_ovf         = coin_sum[CREDIT_W];
    coin_ok          = coin_valid && !coin_ovf &&
                       ((state_q == StIdle) || (state_q == StCollect));
    credit_with_coin = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;
    sel_new          = {1'b0, credit_with_coin} - {1'b0, price};
    sel_ok           = !sel_new[CREDIT_W];
    armed            = (start_timer == tmr_prev_q) && !arm_wait_q;
`ifdef CANCEL_BUTTON_EN
    cancel_evt       = cancel && (state_q == StCollect);
`else
    cancel_evt       = 1'b0;
`endif
  end

  // Arming window: timeout_flag is blind for two cycles after any mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_prev_q <= TMR_IDLE;
      arm_wait_q <= 1'b0;
    end else begin
      tmr_prev_q <= start_timer;
      arm_wait_q <= (start_timer != tmr_prev_q);
    end
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      restart_q      <= 1'b0;
      start_timer    <= TMR_IDLE;
      dispense_valid <= 1'b0;
      dispense_id    <= 2'd0;
      change_valid   <= 1'b0;
      change_amount  <= '0;
      credit         <= '0;
      coin_reject    <= 1'b0;
      sel_deny       <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (coin_valid && coin_ovf) begin
            coin_reject <= 1'b1;
          end else if (coin_ok) begin
            credit      <= coin_sum[CREDIT_W-1:0];
            start_timer <= TMR_WAIT_SELECT;
            state_q     <= StCollect;
          end
        end
        StCollect: begin
          if (coin_valid && coin_ovf) coin_reject <= 1'b1;
          if (cancel_evt) begin
            credit        <= credit_with_coin;
            change_valid  <= 1'b1;
            change_amount <= credit_with_coin;
            start_timer   <= TMR_CHANGE_RETURN;
            restart_q     <= 1'b0;
            state_q       <= StChange;
          end else if (sel_valid && sel_ok) begin
            credit         <= sel_new[CREDIT_W-1:0];
            dispense_id    <= sel_id;
            dispense_valid <= 1'b1;
            start_timer    <= TMR_PRODUCT_RETURN;
            restart_q      <= 1'b0;
            state_q        <= StDispense;
          end else begin
            if (sel_valid) sel_deny <= 1'b1;
            if (coin_ok) begin
              // Force one idle cycle so the timer reloads the wait-select count.
              credit      <= coin_sum[CREDIT_W-1:0];
              start_timer <= TMR_IDLE;
              restart_q   <= 1'b1;
            end else if (restart_q) begin
              start_timer <= TMR_WAIT_SELECT;
              restart_q   <= 1'b0;
            end else if (!sel_valid && timeout_flag && armed) begin
              change_valid  <= 1'b1;
              change_amount <= credit;
              start_timer   <= TMR_CHANGE_RETURN;
              state_q       <= StChange;
            end
          end
        end
        StDispense: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (timeout_flag && armed) begin
            dispense_valid <= 1'b0;
            dispense_id    <= 2'd0;
            if (credit != '0) begin
              change_valid  <= 1'b1;
              change_amount <= credit;
              start_timer   <= TMR_CHANGE_RETURN;
              state_q       <= StChange;
            end else begin
              start_timer <= TMR_IDLE;
              state_q     <= StIdle;
            end
          end
        end
        StChange: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (timeout_flag && armed) begin
            credit        <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            start_timer   <= TMR_IDLE;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          start_timer <= TMR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Control FSM for the vending machine, acting as the initiator of the timer interface.
- Accepts coins and product selections and drives `start_timer` to open each timed phase: wait-select, product-return and change-return.
- Consumes the timer's `timeout_flag` to close each phase.
- Drives the dispense and change outputs to the mechanism and display blocks.

Parameters:
- CREDIT_W, 8: width of credit, coin value and change amount.
- PRICE0, 8'd10: price of product 0.
- PRICE1, 8'd15: price of product 1.
- PRICE2, 8'd20: price of product 2.
- PRICE3, 8'd25: price of product 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle pulse, coin inserted.
- coin_value  in  CREDIT_W  value of the coin, qualified by coin_valid.
- sel_valid  in  1  one-cycle pulse, product selected.
- sel_id  in  2  product index, qualified by sel_valid.
- timeout_flag  in  1  from timer; high while the loaded count has expired.
- start_timer  out  2  timer mode: 00 wait-select, 01 product-return, 10 change-return, 11 idle/reload.
- dispense_valid  out  1  held high for the whole product-return phase.
- dispense_id  out  2  product being dispensed.
- change_valid  out  1  held high for the whole change-return phase.
- change_amount  out  CREDIT_W  change returned.
- credit  out  CREDIT_W  current credit, for the display.
- coin_reject  out  1  one-cycle pulse, coin refused.
- sel_deny  out  1  one-cycle pulse, credit insufficient for the selection.

Behaviour:
- Reset: state IDLE; start_timer=11; credit=0; all other outputs 0. All outputs are registered.
- Timer contract: the timer reloads its count whenever start_timer changes value.
  - A phase is opened by moving start_timer from 11 to the phase code.
  - Restarting the same phase forces 11 for exactly one cycle before the code is reapplied.
  - timeout_flag is ignored in the first two cycles after any start_timer change (the arming window), then sampled every cycle.
- IDLE (start_timer=11): an accepted coin adds coin_value to credit and moves to COLLECT. Selections in IDLE are ignored.
- COLLECT (start_timer=00):
  - Each accepted coin adds to credit and restarts the wait-select timer (11 for 1 cycle, then 00).
  - On sel_valid, compute new = credit + coin (if coin_valid is also high) − PRICE[sel_id], in CREDIT_W+1 bits.
    - If new ≥ 0: credit ← new, latch dispense_id ← sel_id, go to DISPENSE.
    - If new < 0: pulse sel_deny and stay in COLLECT (any coin is still added).
  - On an armed timeout_flag: go to CHANGE with change_amount = credit (full refund).
- DISPENSE (start_timer=01):
  - dispense_valid=1.
  - On an armed timeout_flag: dispense_valid=0; go to CHANGE if credit≠0, else IDLE.
- CHANGE (start_timer=10):
  - change_valid=1 and change_amount=credit, both latched on entry.
  - On an armed timeout_flag: credit←0, change_valid=0, change_amount←0, go to IDLE.
- Coin acceptance:
  - Coins are accepted only in IDLE and COLLECT.
  - Any coin_valid in DISPENSE or CHANGE pulses coin_reject the next cycle and leaves credit unchanged.
  - A coin whose sum would exceed 2^CREDIT_W−1 is rejected (coin_reject pulse), credit is unchanged, and no timer restart occurs.
- Simultaneous events in COLLECT: an armed timeout_flag arriving in the same cycle as sel_valid or coin_valid is overridden; the selection or coin wins. A coin restarts the timer; a successful selection goes to DISPENSE.
- Reset asserted mid-phase returns to IDLE immediately and any held credit is lost. No refund phase is run.
- Latency: any transition takes 1 clock from the triggering input to the new start_timer and output values.

Optional Feature:
- Macro CANCEL_BUTTON_EN.
- When defined:
  - Adds input port `cancel` (1 bit, one-cycle pulse).
  - In COLLECT, cancel goes to CHANGE (refund of full credit). cancel outranks sel_valid in the same cycle; a coin arriving in that same cycle is still accepted and included in the refund.
  - cancel is ignored in the other states.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package vend_pkg holds:
  - state encoding (IDLE, COLLECT, DISPENSE, CHANGE);
  - timer mode constants TMR_WAIT_SELECT=2'b00, TMR_PRODUCT_RETURN=2'b01, TMR_CHANGE_RETURN=2'b10, TMR_IDLE=2'b11;
  - the CREDIT_W default.
- One sub-module, price_lookup: combinational map from sel_id to price using the PRICE0..PRICE3 parameters.
- The FSM, credit arithmetic and arming counter stay in vend_sequencer.

Test Plan (timer instance in the bench with TIME_WAIT_SELECT=10, TIME_PRODUCT_RETURN=4, TIME_CHANGE_RETURN=3):
- Insert coin 20, select id 1 (price 15) -> start_timer 00→01, dispense_valid with id=1 for ~4 cycles, then 10 with change_amount=5, then 11 and credit=0.
- Insert coin 10, select id 3 -> sel_deny pulse, credit stays 10, state remains COLLECT. Insert coin 15, select id 3 -> dispense, no CHANGE phase, return to IDLE.
- Insert coin 5, then no selection -> timeout after ~10 cycles -> CHANGE with change_amount=5.
- Insert coin 5, then coin 5 at cycle 8 -> start_timer shows 11 for 1 cycle then 00. Timeout occurs ~10 cycles after the second coin; refund=10.
- Coin 10 pulsed during DISPENSE; credit 250 plus coin 10 in COLLECT -> coin_reject pulse each time, credit unchanged (0 and 250 respectively).
- Assert rst_n low during CHANGE -> all outputs return to reset values asynchronously; start_timer=11.
